seg_display_arbiter: RTL and testbench

Round-robin arbiter that shares the single 4-digit seven-segment display driver between up to NUM_REQ producers, for example a counter, a status word and a debug register. Each producer raises a request with a 16-bit hex word. The arbiter grants one producer at a time and guarantees a minimum on-screen hold time. It forwards the owner's word to the display driver's 16-bit data input.

---
 rtl/seg_display_arbiter_pkg.sv | 22 ++
 rtl/seg_display_arbiter_if.sv | 35 +++
 rtl/seg_display_arbiter_rr_pick.sv | 34 +++
 rtl/seg_display_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | disp_pkg : shared state encoding and word constants for display arbiters    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam int WORD_W  = 4 * DIGIT_W;

  localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage : disp_pkg

`default_nettype wire

// File: rtl/seg_display_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | seg_display_arbiter_if : requester/display bundle for seg_display_arbiter   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seg_display_arbiter_if
  import disp_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [WORD_W*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          owner_id;
  logic                      active;
  logic                      blank;
  logic [WORD_W-1:0]         data_out;

  modport master (
    output req, data_in,
    input  grant, owner_id, active, blank, data_out
  );

  modport slave (
    input  req, data_in,
    output grant, owner_id, active, blank, data_out
  );

endinterface : seg_display_arbiter_if

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin priority encoder (search from last+1)   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic               found,
  output logic [IDX_W-1:0]   winner_idx
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    found      = 1'b0;
    winner_idx = '0;
    idx        = '0;
    // The last winner is visited last, so it only wins when nobody else asks.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last_winner) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        winner_idx = idx;
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// +----------------------------------------------------------------------------+
// | seg_display_arbiter : round-robin owner of a shared 4-digit 7-seg display   |
// | Optional blank gap between owners: define DISP_ARB_GAP_EN                   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_display_arbiter
  import disp_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                HOLD_CYCLES = 1024,
  parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEFAULT,
  parameter int                GAP_CYCLES  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  seg_display_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic                   active_q, active_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic                   owner_req;
  logic                   others_req;
  logic                   release_own;
  logic [WORD_W-1:0]      words [NUM_REQ];

`ifdef DISP_ARB_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   blank_q, blank_d;
`else
  localparam int unused_gap_cycles = GAP_CYCLES;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.data_in[WORD_W*i +: WORD_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req         (bus.req),
    .last_winner (last_q),
    .found       (found),
    .winner_idx  (winner)
  );

  assign owner_req   = |(bus.req & grant_q);
  assign others_req  = |(bus.req & ~grant_q);
  assign release_own = !owner_req || ((hold_q == HOLD_W'(HOLD_CYCLES)) && others_req);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    active_d = active_q;
    data_d   = data_q;
    hold_d   = hold_q;
    last_d   = last_q;
`ifdef DISP_ARB_GAP_EN
    gap_d    = gap_q;
    blank_d  = 1'b0;
`endif

    case (state_q)
      ST_OWN: begin
        if (release_own) begin
`ifdef DISP_ARB_GAP_EN
          state_d  = ST_GAP;
          grant_d  = '0;
          owner_d  = '0;
          active_d = 1'b0;
          data_d   = IDLE_WORD;
          gap_d    = '0;
          blank_d  = 1'b1;
`else
          // Direct handoff: the grant never passes through zero.
          if (found) begin
            state_d  = ST_OWN;
            grant_d  = NUM_REQ'(1) << winner;
            owner_d  = winner;
            active_d = 1'b1;
            data_d   = words[winner];
            hold_d   = '0;
            last_d   = winner;
          end else begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            owner_d  = '0;
            active_d = 1'b0;
            data_d   = IDLE_WORD;
          end
`endif
        end else begin
          data_d = words[owner_q];
          if (hold_q != HOLD_W'(HOLD_CYCLES)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

`ifdef DISP_ARB_GAP_EN
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q + GAP_W'(1);
          blank_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        if (found) begin
          state_d  = ST_OWN;
          grant_d  = NUM_REQ'(1) << winner;
          owner_d  = winner;
          active_d = 1'b1;
          data_d   = words[winner];
          hold_d   = '0;
          last_d   = winner;
        end else begin
          grant_d  = '0;
          owner_d  = '0;
          active_d = 1'b0;
          data_d   = IDLE_WORD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      active_q <= 1'b0;
      data_q   <= IDLE_WORD;
      hold_q   <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
`ifdef DISP_ARB_GAP_EN
      gap_q    <= '0;
      blank_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
`ifdef DISP_ARB_GAP_EN
      gap_q    <= gap_d;
      blank_q  <= blank_d;
`endif
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner_id = owner_q;
  assign bus.active   = active_q;
  assign bus.data_out = data_q;
`ifdef DISP_ARB_GAP_EN
  assign bus.blank    = blank_q;
`else
  assign bus.blank    = 1'b0;
`endif

endmodule : seg_display_arbiter

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_seg_display_arbiter : directed self-checking bench, NUM_REQ=4, HOLD=8    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 8;
  localparam int GAP     = 4;
`ifdef DISP_ARB_GAP_EN
  localparam bit GAP_EN  = 1'b1;
`else
  localparam bit GAP_EN  = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seg_display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  seg_display_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .IDLE_WORD   (16'h0000),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    bus.data_in[16*i +: 16] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.owner_id !== 2'd0 ||
        bus.blank !== 1'b0 || bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b active=%b owner=%0d blank=%b data=%h, want 0000 0 0 0 0000",
               bus.grant, bus.active, bus.owner_id, bus.blank, bus.data_out);
    end
    set_word(2, 16'h2222);
    bus.req = 4'b0100;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0100 || bus.owner_id !== 2'd2 || bus.data_out !== 16'h2222) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b owner=%0d data=%h, want 0100 2 2222",
               bus.grant, bus.owner_id, bus.data_out);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_grant: grant=%b active=%b data=%h, want 0000 0 0000",
               bus.grant, bus.active, bus.data_out);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0100 || bus.owner_id !== 2'd2 || bus.active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_regrant: grant=%b owner=%0d active=%b, want 0100 2 1",
               bus.grant, bus.owner_id, bus.active);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_word(0, 16'h1234);
    bus.req = 4'b0001;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.data_out !== 16'h1234 || bus.active !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b data=%h active=%b, want 0001 1234 1",
               bus.grant, bus.data_out, bus.active);
    end
    set_word(0, 16'hABCD);
    tick();
    n_checks++;
    if (bus.data_out !== 16'hABCD) begin
      n_fail++;
      $display("FAIL single_live_update: data=%h, want abcd", bus.data_out);
    end
    // Alone past the hold limit: ownership must persist.
    repeat (3 * HOLD) tick();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.data_out !== 16'hABCD) begin
      n_fail++;
      $display("FAIL single_hold_saturate: grant=%b data=%h, want 0001 abcd",
               bus.grant, bus.data_out);
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.data_out !== 16'h0000 ||
        bus.blank !== GAP_EN) begin
      n_fail++;
      $display("FAIL single_release: grant=%b active=%b data=%h blank=%b, want 0000 0 0000 %b",
               bus.grant, bus.active, bus.data_out, bus.blank, GAP_EN);
    end
  endtask

`ifndef DISP_ARB_GAP_EN
  task automatic test_preempt();
    logic [3:0] exp_g;
    int len;
    do_reset();
    set_word(0, 16'h000A);
    set_word(1, 16'h000B);
    bus.req = 4'b0011;
    tick();
    for (int k = 0; k < 2; k++) begin
      exp_g = (k == 0) ? 4'b0001 : 4'b0010;
      n_checks++;
      if (bus.grant !== exp_g || bus.data_out !== ((k == 0) ? 16'h000A : 16'h000B)) begin
        n_fail++;
        $display("FAIL preempt_owner%0d: grant=%b data=%h, want %b", k, bus.grant, bus.data_out, exp_g);
      end
      len = 0;
      while (bus.grant === exp_g && len < 40) begin
        len++;
        tick();
      end
      n_checks++;
      if (len !== HOLD + 1) begin
        n_fail++;
        $display("FAIL preempt_window%0d: held %0d cycles, want %0d", k, len, HOLD + 1);
      end
    end
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL preempt_return: grant=%b, want 0001", bus.grant);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    int len;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_word(i, 16'hF000 + 16'(i));
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_g = 4'b0001 << k;
      n_checks++;
      if (bus.grant !== exp_g || bus.owner_id !== 2'(k) || bus.data_out !== 16'hF000 + 16'(k)) begin
        n_fail++;
        $display("FAIL rr_order%0d: grant=%b owner=%0d data=%h, want %b %0d", k,
                 bus.grant, bus.owner_id, bus.data_out, exp_g, k);
      end
      len = 0;
      while (bus.grant === exp_g && len < 40) begin
        len++;
        tick();
      end
      n_checks++;
      if (len !== HOLD + 1) begin
        n_fail++;
        $display("FAIL rr_window%0d: held %0d cycles, want %0d", k, len, HOLD + 1);
      end
    end
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_wrap: grant=%b, want 0001", bus.grant);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    set_word(1, 16'h1111);
    set_word(3, 16'h3333);
    bus.req = 4'b1000;
    tick();
    n_checks++;
    if (bus.grant !== 4'b1000 || bus.owner_id !== 2'd3) begin
      n_fail++;
      $display("FAIL early_first: grant=%b owner=%0d, want 1000 3", bus.grant, bus.owner_id);
    end
    bus.req = 4'b1010;
    tick();
    tick();
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0010 || bus.owner_id !== 2'd1 || bus.data_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL early_release: grant=%b owner=%0d data=%h, want 0010 1 1111",
               bus.grant, bus.owner_id, bus.data_out);
    end
  endtask
`endif

`ifdef DISP_ARB_GAP_EN
  task automatic test_gap();
    int len;
    do_reset();
    set_word(0, 16'h000A);
    set_word(1, 16'h000B);
    bus.req = 4'b0011;
    tick();
    len = 0;
    while (bus.grant === 4'b0001 && len < 40) begin
      len++;
      tick();
    end
    n_checks++;
    if (len !== HOLD + 1) begin
      n_fail++;
      $display("FAIL gap_window: held %0d cycles, want %0d", len, HOLD + 1);
    end
    len = 0;
    while (bus.grant === 4'b0000 && bus.blank === 1'b1 && bus.data_out === 16'h0000 && len < 40) begin
      len++;
      tick();
    end
    n_checks++;
    if (len !== GAP) begin
      n_fail++;
      $display("FAIL gap_length: %0d blank cycles, want %0d", len, GAP);
    end
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.blank !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_idle_cycle: grant=%b blank=%b, want 0000 0", bus.grant, bus.blank);
    end
    tick();
    n_checks++;
    if (bus.grant !== 4'b0010 || bus.data_out !== 16'h000B) begin
      n_fail++;
      $display("FAIL gap_next_owner: grant=%b data=%h, want 0010 000b", bus.grant, bus.data_out);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.req      = '0;
    bus.data_in  = '0;
    test_reset();
    test_single();
`ifdef DISP_ARB_GAP_EN
    test_gap();
`else
    test_preempt();
    test_fairness();
    test_early_release();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg_display_arbiter

`default_nettype wire
